// File: rtl/fw_gfx_pkg.sv
// -----------------------------------------------------------------------------
// fw_gfx_pkg
// Shared graphics definitions for the Fireboy/Watergirl sprite pipeline:
// screen geometry, coordinate and palette-index types, the default transparent
// palette index, the walk-animation state encoding, and a width helper for
// parameter-derived bus widths.
// -----------------------------------------------------------------------------
package fw_gfx_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] pal_idx_t;

    localparam pal_idx_t TRANSP_IDX_DEFAULT = 4'd0;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;

    // Bits needed to hold 0..n-1, never less than one so a single-value
    // counter still has a legal width.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// -----------------------------------------------------------------------------
// sprite_anim_ctr
// Walk-animation frame counter shared by the character sprites. Everything
// advances only on frame ticks, so the frame number is stable for a whole
// video frame.
//
// Ports:
//   clk_i        pixel clock
//   reset_i      synchronous active-high reset
//   tick_i       one-cycle pulse per video frame
//   moving_i     character is walking this frame
//   anim_frame_o current animation frame (0 .. NUM_FRAMES-1)
// -----------------------------------------------------------------------------
module sprite_anim_ctr
    import fw_gfx_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned ANIM_DIV   = 6,
    localparam int unsigned FRAME_W   = width_of(NUM_FRAMES)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               moving_i,
    output logic [FRAME_W-1:0] anim_frame_o
);

    localparam int unsigned DIV_W = width_of(ANIM_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    anim_state_t        state_q, state_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    // State, divider and frame registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            div_q   <= {DIV_W{1'b0}};
            frame_q <= {FRAME_W{1'b0}};
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic; only a frame tick can change anything.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        frame_d = frame_q;
        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    div_d   = {DIV_W{1'b0}};
                    frame_d = {FRAME_W{1'b0}};
                    if (moving_i) begin
                        state_d = WALK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WALK: begin
                    if (moving_i) begin
                        state_d = WALK;
                        if (div_q == DIV_LAST) begin
                            div_d = {DIV_W{1'b0}};
                            if (frame_q == FRAME_LAST) begin
                                frame_d = {FRAME_W{1'b0}};
                            end else begin
                                frame_d = frame_q + FRAME_W'(1);
                            end
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end else begin
                        // Stopping snaps back to the standing frame at once.
                        state_d = IDLE;
                        div_d   = {DIV_W{1'b0}};
                        frame_d = {FRAME_W{1'b0}};
                    end
                end
                default: begin
                    state_d = IDLE;
                    div_d   = {DIV_W{1'b0}};
                    frame_d = {FRAME_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
            div_d   = div_q;
            frame_d = frame_q;
        end
    end

    assign anim_frame_o = frame_q;

endmodule

// File: rtl/boy_sprite_fetch.sv
// -----------------------------------------------------------------------------
// boy_sprite_fetch
// Per-pixel Fireboy sprite fetch. Stage 0 tests whether the pixel lies inside
// the sprite box and forms the ROM address (frame, row, mirrored column);
// stage 1 registers the address; stage 2 registers the returned palette index
// and the opaque flag. Output is exactly two clocks behind DrawX/DrawY.
//
// Ports:
//   Clk, Reset          pixel clock, synchronous active-high reset
//   frame_tick          one pulse per frame; latches position/facing, steps animation
//   DrawX, DrawY        current pixel
//   blank               1 = active video
//   boy_x, boy_y        sprite top-left corner
//   moving, facing_left walking flag, horizontal mirror
//   rom_addr / rom_data sprite ROM address out, palette index back (same cycle
//                       as the registered address)
//   palette_index       index for the palette stage
//   sprite_on           opaque sprite pixel at this output cycle
//   anim_frame          current walk-animation frame
// -----------------------------------------------------------------------------
module boy_sprite_fetch
    import fw_gfx_pkg::*;
#(
    parameter int unsigned SPRITE_W   = 24,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned ANIM_DIV   = 6,
    parameter pal_idx_t    TRANSP_IDX = TRANSP_IDX_DEFAULT,
    parameter int unsigned ADDR_W     = 12,
    localparam int unsigned FRAME_W   = width_of(NUM_FRAMES)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic [9:0]         boy_x,
    input  logic [9:0]         boy_y,
    input  logic               moving,
    input  logic               facing_left,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [3:0]         rom_data,
    output logic [3:0]         palette_index,
    output logic               sprite_on,
    output logic [FRAME_W-1:0] anim_frame
);

    localparam logic [10:0]       SPR_W11     = 11'(SPRITE_W);
    localparam logic [10:0]       SPR_H11     = 11'(SPRITE_H);
    localparam logic [ADDR_W-1:0] SPR_W_A     = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] FRAME_PIX_A = ADDR_W'(SPRITE_W * SPRITE_H);
    localparam logic [ADDR_W-1:0] COL_LAST_A  = ADDR_W'(SPRITE_W - 1);

    // Frame-latched copies of position and facing.
    coord_t sx_q, sy_q;
    logic   face_q;

    logic [FRAME_W-1:0] anim_frame_s;

    // Stage 0 combinational results.
    logic              hit0_s;
    logic [9:0]        dx_s, dy_s;
    logic [ADDR_W-1:0] col_s, row_s, addr0_s;

    // Pipeline registers.
    logic [ADDR_W-1:0] rom_addr_q;
    logic              hit1_q;
    pal_idx_t          pal_q;
    logic              sprite_on_q;

    sprite_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .ANIM_DIV   (ANIM_DIV)
    ) u_anim (
        .clk_i        (Clk),
        .reset_i      (Reset),
        .tick_i       (frame_tick),
        .moving_i     (moving),
        .anim_frame_o (anim_frame_s)
    );

    // Shadow position/facing, refreshed only at the frame boundary so a
    // mid-frame move never tears the sprite.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx_q   <= 10'd0;
            sy_q   <= 10'd0;
            face_q <= 1'b0;
        end else if (frame_tick) begin
            sx_q   <= boy_x;
            sy_q   <= boy_y;
            face_q <= facing_left;
        end else begin
            sx_q   <= sx_q;
            sy_q   <= sy_q;
            face_q <= face_q;
        end
    end

    // Stage 0: box test and ROM address. The box test runs in 11 bits so a
    // sprite hanging past column 1023 does not wrap onto the left edge.
    always_comb begin
        hit0_s = blank
              && ({1'b0, DrawX} >= {1'b0, sx_q})
              && ({1'b0, DrawX} <  ({1'b0, sx_q} + SPR_W11))
              && ({1'b0, DrawY} >= {1'b0, sy_q})
              && ({1'b0, DrawY} <  ({1'b0, sy_q} + SPR_H11));
        dx_s  = DrawX - sx_q;
        dy_s  = DrawY - sy_q;
        row_s = ADDR_W'(dy_s);
        if (face_q) begin
            col_s = COL_LAST_A - ADDR_W'(dx_s);
        end else begin
            col_s = ADDR_W'(dx_s);
        end
        addr0_s = ADDR_W'(anim_frame_s) * FRAME_PIX_A + row_s * SPR_W_A + col_s;
    end

    // Stage 1: address register holds its last value on misses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q <= {ADDR_W{1'b0}};
            hit1_q     <= 1'b0;
        end else begin
            hit1_q <= hit0_s;
            if (hit0_s) begin
                rom_addr_q <= addr0_s;
            end else begin
                rom_addr_q <= rom_addr_q;
            end
        end
    end

    // Stage 2: palette index and opaque flag from the ROM word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pal_q       <= 4'd0;
            sprite_on_q <= 1'b0;
        end else begin
            pal_q       <= hit1_q ? rom_data : TRANSP_IDX;
            sprite_on_q <= hit1_q && (rom_data != TRANSP_IDX);
        end
    end

    assign rom_addr      = rom_addr_q;
    assign palette_index = pal_q;
    assign sprite_on     = sprite_on_q;
    assign anim_frame    = anim_frame_s;

endmodule

// File: doc/boy_sprite_fetch.md
Name: boy_sprite_fetch

Overview:
- Sits directly upstream of the boy sprite palette lookup.
- Per VGA pixel: decides whether (DrawX, DrawY) falls inside the Fireboy sprite box, then computes the sprite ROM address from the animation frame, row, column and facing (with horizontal mirroring).
- Returns the ROM's 4-bit palette index with a hit/transparency flag, pipeline-aligned to the pixel stream.
- Also owns the walk-animation frame counter, advanced on frame ticks.

Parameters:
- SPRITE_W, 24, sprite width in pixels.
- SPRITE_H, 32, sprite height in pixels.
- NUM_FRAMES, 4, walk-animation frames stored consecutively in ROM.
- ANIM_DIV, 6, frame ticks per animation step.
- TRANSP_IDX, 0, palette index treated as transparent.
- ADDR_W, 12, ROM address width; must be >= clog2(NUM_FRAMES*SPRITE_W*SPRITE_H).

Ports:
- Clk, input, 1, pixel clock.
- Reset, input, 1, synchronous, active-high.
- frame_tick, input, 1, one-cycle pulse per video frame (start of vertical blank).
- DrawX, input, 10, current pixel column.
- DrawY, input, 10, current pixel row.
- blank, input, 1, 1 = active video.
- boy_x, input, 10, sprite top-left column.
- boy_y, input, 10, sprite top-left row.
- moving, input, 1, character walking this frame.
- facing_left, input, 1, mirror sprite horizontally.
- rom_addr, output, ADDR_W, registered address to sprite ROM.
- rom_data, input, 4, ROM palette index (1-cycle read latency from rom_addr).
- palette_index, output, 4, index presented to the palette stage.
- sprite_on, output, 1, 1 = opaque sprite pixel at this output cycle.
- anim_frame, output, clog2(NUM_FRAMES), current animation frame.

Behaviour:
- Reset: rom_addr=0, palette_index=0, sprite_on=0, anim_frame=0, tick divider=0, all pipeline valid bits=0, latched facing/pos=0.
- Frame-state latch:
  - On frame_tick, latch boy_x, boy_y, facing_left into shadow registers.
  - Addressing uses only shadow values, so there is no mid-frame tearing.
- Animation FSM, states IDLE and WALK, evaluated only on frame_tick:
  - IDLE: anim_frame=0, divider=0. Go to WALK when moving=1.
  - WALK, moving=1: divider increments. When divider reaches ANIM_DIV-1, divider returns to 0 and anim_frame=(anim_frame+1) mod NUM_FRAMES, wrapping from NUM_FRAMES-1 to 0.
  - WALK, moving=0: go to IDLE; anim_frame=0 and divider=0 on the same tick.
- Stage 0 (comb): hit0 = blank && DrawX in [sx, sx+SPRITE_W-1] && DrawY in [sy, sy+SPRITE_H-1].
  - Comparisons use 11-bit unsigned math, so a box extending past column 1023 does not wrap.
  - col = DrawX-sx; row = DrawY-sy.
  - When mirrored: col = SPRITE_W-1-col.
- Stage 1 (reg): rom_addr <= anim_frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col when hit0, else rom_addr holds its value. hit1 <= hit0.
- Stage 2 (reg): palette_index <= hit1 ? rom_data : TRANSP_IDX. sprite_on <= hit1 && (rom_data != TRANSP_IDX).
- Latency: exactly 2 Clk from DrawX/DrawY to palette_index/sprite_on. The downstream stage delays its own DrawX/blank by 2 to match.
- Simultaneous frame_tick with an in-flight pixel:
  - Pipeline contents are unaffected.
  - The new anim_frame and shadow values apply from the next stage-0 evaluation.
- Reset mid-line: the pipeline flushes; sprite_on=0 for the 2 cycles after Reset deasserts.
- anim_frame is stable for a whole frame; it never changes while blank=1 except at the frame_tick cycle.

Decomposition:
- Shared package fw_gfx_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480.
  - Coordinate typedef coord_t (logic [9:0]).
  - Palette index typedef pal_idx_t (logic [3:0]).
  - TRANSP_IDX default.
  - anim_state_t enum {IDLE, WALK}.
- One sub-module: sprite_anim_ctr (FSM + divider + anim_frame), reusable for the Watergirl sprite.

Test Plan:
- Reset held 3 cycles mid-line with boy inside box -> sprite_on=0, palette_index=0, anim_frame=0, rom_addr=0; first valid output 2 cycles after release.
- shadow pos (100,200), facing right, frame 0; DrawX=105, DrawY=210 -> rom_addr=10*24+5=245 one cycle later. rom_data=7 -> palette_index=7, sprite_on=1 at cycle+2.
- Same pixel with facing_left=1 -> col=24-1-5=18, rom_addr=258.
- rom_data=0 inside box -> palette_index=0, sprite_on=0.
- DrawX=124 (one past right edge) -> sprite_on=0.
- blank=0 inside box -> sprite_on=0.
- moving=1 for 30 frame_ticks -> anim_frame steps 0→1 at tick 6 (counting from the IDLE→WALK tick), wraps 3→0 at tick 24, reaches 1 at tick 30.
- moving drops at tick 14 -> anim_frame=0 on that tick.
- Box at x=1010 -> pixels with DrawX 1010..1023 hit; no hit at DrawX 0..9 (no wrap).
- boy_x changes mid-frame -> rom_addr is unaffected until the next frame_tick.
